axi_lite_slave_regs: RTL and testbench

- AXI4-Lite responder: terminates the five AXI4-Lite channels issued by the team's master and backs them with a word-addressed register bank.
- Independent write and read state machines.
- Returns OKAY, SLVERR or DECERR so the master's unaligned and unmapped cases get a defined response.
- Sits on the slave side of axi_lite_top; replaces ad-hoc memory models in system benches.

---
 rtl/axi_lite_slave_regs.sv | 208 ++++++++++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder backed by a word-addressed register bank with independent write/read FSMs.
// Optional macro AXIL_STRB_EN enables per-byte write strobes; without it every OKAY write updates the full word.
module axi_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] MAP_END = ADDR_WIDTH'(4 * NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic [1:0] decode(input logic [ADDR_WIDTH-1:0] a);
    if (a[1:0] != 2'b00) return RESP_SLVERR;
    if (a >= MAP_END)    return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  w_state_t              w_state, w_next;
  logic [ADDR_WIDTH-1:0] aw_addr_q, c_addr;
  logic [DATA_WIDTH-1:0] wdata_q, c_data, wr_word;
  logic [STRB_W-1:0]     wstrb_q, c_strb;
  logic [1:0]            bresp_q, c_resp;
  logic [IDX_W-1:0]      c_idx;
  logic                  commit, latch_aw, latch_w;

  // The commit source mixes live channel inputs with whichever half was latched earlier.
  always_comb begin
    w_next   = w_state;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    commit   = 1'b0;
    latch_aw = 1'b0;
    latch_w  = 1'b0;
    c_addr   = aw_addr_q;
    c_data   = wdata_q;
    c_strb   = wstrb_q;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        c_addr  = awaddr;
        c_data  = wdata;
        c_strb  = wstrb;
        if (awvalid && wvalid) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else if (awvalid) begin
          latch_aw = 1'b1;
          w_next   = W_WAIT_W;
        end else if (wvalid) begin
          latch_w = 1'b1;
          w_next  = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        wready = 1'b1;
        c_data = wdata;
        c_strb = wstrb;
        if (wvalid) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_WAIT_AW: begin
        awready = 1'b1;
        c_addr  = awaddr;
        if (awvalid) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      default: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
    endcase
    if (rst) begin
      awready  = 1'b0;
      wready   = 1'b0;
      bvalid   = 1'b0;
      commit   = 1'b0;
      latch_aw = 1'b0;
      latch_w  = 1'b0;
      w_next   = W_IDLE;
    end
  end

  assign c_resp = decode(c_addr);
  assign c_idx  = c_addr[IDX_W+1:2];

  always_comb begin
    wr_word = c_data;
`ifdef AXIL_STRB_EN
    for (int b = 0; b < STRB_W; b++)
      if (!c_strb[b]) wr_word[8*b +: 8] = regs[c_idx][8*b +: 8];
`endif
  end

`ifndef AXIL_STRB_EN
  logic unused_strb;
  assign unused_strb = ^c_strb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      w_state <= w_next;
      if (latch_aw) aw_addr_q <= awaddr;
      if (latch_w) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit) begin
        bresp_q <= c_resp;
        if (c_resp == RESP_OKAY) regs[c_idx] <= wr_word;
      end
    end
  end

  r_state_t              r_state, r_next;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q, ar_resp;
  logic                  ar_take;

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    ar_take = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          ar_take = 1'b1;
          r_next  = R_DATA;
        end
      end
      default: begin
        rvalid = 1'b1;
        if (rready) r_next = R_IDLE;
      end
    endcase
    if (rst) begin
      arready = 1'b0;
      rvalid  = 1'b0;
      ar_take = 1'b0;
      r_next  = R_IDLE;
    end
  end

  assign ar_resp = decode(araddr);

  // Nonblocking register update means a same-cycle write is not yet visible here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_take) begin
        rresp_q <= ar_resp;
        rdata_q <= (ar_resp == RESP_OKAY) ? regs[araddr[IDX_W+1:2]] : '0;
      end
    end
  end

  assign bresp = rst ? 2'b00 : bresp_q;
  assign rresp = rst ? 2'b00 : rresp_q;
  assign rdata = rst ? '0 : rdata_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: directed scenarios plus randomized traffic
// checked against an array-based register model.
module tb_axi_lite_slave_regs;

  localparam int NUM_REGS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [NUM_REGS];

  axi_lite_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    if (a % 4 != 0) return 2'b10;
    if (a >= 4 * NUM_REGS) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (exp_resp(a) != 2'b00) return 32'h0;
    return mdl[a / 4];
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (exp_resp(a) != 2'b00) return;
`ifdef AXIL_STRB_EN
    for (int b = 0; b < 4; b++)
      if (s[b]) mdl[a / 4][8*b +: 8] = d[8*b +: 8];
`else
    mdl[a / 4] = d;
`endif
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = 32'h0;
  endtask

  // mode 0: AW+W together; 1: AW then W after gap; 2: W then AW after gap
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int mode, input int gap, input int bp);
    logic [1:0] er;
    er = exp_resp(a);
    if (mode == 0) begin
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
      #1 check_val("idle_awready", awready, 1);
      check_val("idle_wready", wready, 1);
    end else if (mode == 1) begin
      awaddr = a; awvalid = 1;
      #1 check_val("idle_awready", awready, 1);
      @(posedge clk); #1;
      awvalid = 0; awaddr = $urandom;
      check_val("wait_w_awready", awready, 0);
      repeat (gap) begin
        check_val("wait_w_bvalid", bvalid, 0);
        @(posedge clk); #1;
      end
      wdata = d; wstrb = s; wvalid = 1;
      #1 check_val("wait_w_wready", wready, 1);
    end else begin
      wdata = d; wstrb = s; wvalid = 1;
      #1 check_val("idle_wready", wready, 1);
      @(posedge clk); #1;
      wvalid = 0; wdata = $urandom; wstrb = 4'($urandom);
      check_val("wait_aw_wready", wready, 0);
      repeat (gap) begin
        check_val("wait_aw_bvalid", bvalid, 0);
        @(posedge clk); #1;
      end
      awaddr = a; awvalid = 1;
      #1 check_val("wait_aw_awready", awready, 1);
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; awaddr = $urandom; wdata = $urandom;
    check_val("bvalid_latency", bvalid, 1);
    check_val("bresp", bresp, er);
    mdl_write(a, d, s);
    repeat (bp) begin
      @(posedge clk); #1;
      check_val("bp_bvalid", bvalid, 1);
      check_val("bp_bresp", bresp, er);
      check_val("bp_awready", awready, 0);
      check_val("bp_wready", wready, 0);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    check_val("bvalid_drop", bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input int bp);
    logic [1:0]  er;
    logic [31:0] ed;
    er = exp_resp(a);
    ed = exp_rdata(a);
    araddr = a; arvalid = 1;
    #1 check_val("idle_arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 0; araddr = $urandom;
    check_val("rvalid_latency", rvalid, 1);
    check_val("rresp", rresp, er);
    check_val("rdata", rdata, ed);
    repeat (bp) begin
      @(posedge clk); #1;
      check_val("bp_rvalid", rvalid, 1);
      check_val("bp_rdata", rdata, ed);
      check_val("bp_rresp", rresp, er);
      check_val("bp_arready", arready, 0);
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    check_val("rvalid_drop", rvalid, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 6) return 32'($urandom_range(0, NUM_REGS - 1)) * 4;
    if (k < 8) return 32'($urandom_range(0, NUM_REGS - 1)) * 4 + 32'($urandom_range(1, 3));
    return 32'(4 * NUM_REGS) + ($urandom & 32'h0000_FFFF);
  endfunction

  initial begin
    logic [31:0] old_val;
    rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_awready", awready, 0);
    check_val("rst_wready", wready, 0);
    check_val("rst_arready", arready, 0);
    check_val("rst_bvalid", bvalid, 0);
    check_val("rst_rvalid", rvalid, 0);
    check_val("rst_rdata", rdata, 0);
    rst = 0;
    #1 check_val("post_rst_awready", awready, 1);
    check_val("post_rst_arready", arready, 1);

    do_write(32'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    do_read(32'h10, 0);
    check_val("t1_value", exp_rdata(32'h10), 32'hA5A5A5A5);
    do_write(32'h20, 32'h12345678, 4'hF, 1, 3, 0);
    do_read(32'h20, 0);
    do_write(32'h13, 32'hCAFEBABE, 4'hF, 0, 0, 0);
    do_read(32'h10, 0);
    do_read(32'hFFFF, 0);
    do_write(32'h24, 32'h0BADF00D, 4'hF, 2, 2, 5);
    do_read(32'h24, 5);
    do_write(32'h30, 32'h11223344, 4'hF, 0, 0, 0);
    do_write(32'h40, 32'h55667788, 4'hF, 0, 0, 0);
    do_read(32'h30, 0);
    do_read(32'h40, 0);

    do_write(32'h50, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(32'h50, 32'h00AB0000, 4'h4, 0, 0, 0);
`ifdef AXIL_STRB_EN
    check_val("strb_model", exp_rdata(32'h50), 32'hFFABFFFF);
`else
    check_val("strb_model", exp_rdata(32'h50), 32'h00AB0000);
`endif
    do_read(32'h50, 0);
    do_write(32'h50, 32'h12121212, 4'h0, 0, 0, 0);
    do_read(32'h50, 0);

    // write commit and AR on the same register in one cycle: read sees the old value
    old_val = mdl[5];
    awaddr = 32'h14; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h14; arvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    check_val("coll_rvalid", rvalid, 1);
    check_val("coll_bvalid", bvalid, 1);
    check_val("coll_rdata", rdata, old_val);
    mdl_write(32'h14, 32'hDEADBEEF, 4'hF);
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    do_read(32'h14, 0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 2),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(rand_addr(), $urandom_range(0, 2));
    end

    // reset while waiting for W abandons the write
    awaddr = 32'h50; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    check_val("abandon_wait_w", awready, 0);
    rst = 1;
    #1 check_val("rst_mid_bvalid", bvalid, 0);
    check_val("rst_mid_wready", wready, 0);
    check_val("rst_mid_rresp", rresp, 0);
    check_val("rst_mid_bresp", bresp, 0);
    @(posedge clk); #1;
    rst = 0;
    mdl_clear();
    repeat (3) begin
      @(posedge clk); #1;
      check_val("abandon_bvalid", bvalid, 0);
    end
    do_read(32'h50, 0);
    do_read(32'h10, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
